// File: rtl/team_06_i2s_pkg.sv
// Shared types and constants for the I2S capture sequencer.
package team_06_i2s_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, RUN, DRAIN} state_t;

  localparam int BITS_PER_CH_DEF = 32;
  localparam int MIN_HALF_DIV = 2;
  localparam logic [7:0] SAMPLE_MIDSCALE = 8'd128;
endpackage

// File: rtl/team_06_i2s_clk_div.sv
// I2S bit-clock divider: half-period latch/clamp, counter, sclk, sclk_q and the
// fall tick (asserted in the clk cycle whose edge drives sclk 1->0).
module team_06_i2s_clk_div
  import team_06_i2s_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] div_cfg,
  output logic             sclk,
  output logic             sclk_q,
  output logic             fall_tick
);
  logic [DIV_W-1:0] h, div_cnt, h_clamped;
  logic             at_wrap;

  assign h_clamped = (div_cfg < DIV_W'(MIN_HALF_DIV)) ? DIV_W'(MIN_HALF_DIV) : div_cfg;
  // h >= 2 always, so the load cycle (cnt==0) can never hit a wrap with a stale h
  assign at_wrap   = (div_cnt == h - DIV_W'(1));
  assign fall_tick = run && sclk && at_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h       <= DIV_W'(MIN_HALF_DIV);
      div_cnt <= '0;
      sclk    <= 1'b0;
      sclk_q  <= 1'b0;
    end else begin
      sclk_q <= sclk;
      if (load) h <= h_clamped;
      if (!run) begin
        div_cnt <= '0;
        sclk    <= 1'b0;
      end else if (at_wrap) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end
endmodule

// File: rtl/team_06_i2s_frame_ctrl.sv
// ADC-to-I2S capture sequencer: frame FSM, bit counter, word select, and the
// sample holding register with valid/ready hand-off and sticky overrun.
module team_06_i2s_frame_ctrl
  import team_06_i2s_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int BITS_PER_CH = BITS_PER_CH_DEF,
  parameter int SAMPLE_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DIV_W-1:0]    div_cfg,
  output logic                sclk,
  output logic                sclk_q,
  output logic                ws,
  output logic                capture_en,
  output logic [4:0]          bit_idx,
  output logic                frame_start,
  input  logic                sample_done,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                overrun,
  input  logic                clr_ovr,
  output logic                busy
);
  state_t state, state_nxt;
  logic   sync_first, div_run, div_load, fall_tick, last_bit, frame_end;

  assign last_bit  = (bit_idx == 5'(BITS_PER_CH - 1));
  assign frame_end = fall_tick && last_bit && ws;

  team_06_i2s_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .run       (div_run),
    .div_cfg   (div_cfg),
    .sclk      (sclk),
    .sclk_q    (sclk_q),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en)        state_nxt = SYNC;
      SYNC:    if (fall_tick) state_nxt = RUN;
      RUN:     if (!en)       state_nxt = DRAIN;
      DRAIN:   if (frame_end) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    capture_en = (state == RUN) && !ws;
    div_run    = (state != IDLE);
    div_load   = (state == SYNC) && sync_first;
  end

  // H is taken from div_cfg during the first SYNC cycle only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_first <= 1'b0;
    else     sync_first <= (state == IDLE) && en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws          <= 1'b0;
      bit_idx     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: if (en) begin
          ws      <= 1'b1;
          bit_idx <= '0;
        end
        SYNC: if (fall_tick) begin
          ws          <= 1'b0;
          bit_idx     <= '0;
          frame_start <= 1'b1;
        end
        RUN, DRAIN: if (fall_tick) begin
          if (last_bit) begin
            bit_idx     <= '0;
            ws          <= ~ws;
            // the closing boundary of a drain returns ws to 0 silently
            frame_start <= ws && (state == RUN);
          end else begin
            bit_idx <= bit_idx + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_valid <= 1'b0;
      sample_data  <= SAMPLE_W'(SAMPLE_MIDSCALE);
      overrun      <= 1'b0;
    end else begin
      if (sample_done && (!sample_valid || sample_ready)) begin
        sample_data  <= sample_in;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (sample_done && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (clr_ovr)                                 overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_team_06_i2s_frame_ctrl.sv
// Randomized bench: frame timing predicted from cycle offsets since SYNC entry,
// hand-off predicted by a one-entry holding-register model.
module tb_team_06_i2s_frame_ctrl;
  localparam int BPC = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] div_cfg = 8'd2;
  logic       sample_done = 1'b0, sample_ready = 1'b0, clr_ovr = 1'b0;
  logic [7:0] sample_in = 8'd0;
  logic       sclk, sclk_q, ws, capture_en, frame_start, sample_valid, overrun, busy;
  logic [4:0] bit_idx;
  logic [7:0] sample_data;

  team_06_i2s_frame_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .div_cfg(div_cfg),
    .sclk(sclk), .sclk_q(sclk_q), .ws(ws), .capture_en(capture_en),
    .bit_idx(bit_idx), .frame_start(frame_start),
    .sample_done(sample_done), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .overrun(overrun), .clr_ovr(clr_ovr), .busy(busy)
  );

  always #50 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  bit act = 0;
  int t0 = 0, h = 2, drain_t = -1, stop_t = -1;
  bit prev_sclk = 0;
  bit m_valid = 0, m_ovr = 0;
  logic [7:0] m_data = 8'd128;
  bit e_sclk, e_ws, e_fs, e_cap, e_busy;
  int e_bit;
  bit rnd_hs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected frame outputs from time since SYNC entry: 2H cycles of SYNC,
  // then one bit per 2H cycles, 32 bits per channel, left channel first.
  task automatic frame_exp();
    int t, u, p, k;
    e_sclk = 0; e_ws = 0; e_fs = 0; e_cap = 0; e_busy = 0; e_bit = 0;
    if (!act) return;
    t = cyc - t0; p = 2 * h; e_busy = 1;
    if (t < p) begin
      e_ws = 1; e_sclk = (t >= h);
      return;
    end
    u = t - p; k = u / p;
    e_sclk = ((u % p) >= h);
    e_bit  = k % BPC;
    e_ws   = (((k / BPC) % 2) == 1);
    e_fs   = ((u % (2 * BPC * p)) == 0);
    e_cap  = !e_ws && (drain_t < 0 || t < drain_t);
  endtask

  task automatic check_all();
    chk("sclk", sclk, e_sclk);
    chk("sclk_q", sclk_q, prev_sclk);
    chk("ws", ws, e_ws);
    chk("bit_idx", bit_idx, e_bit);
    chk("frame_start", frame_start, e_fs);
    chk("capture_en", capture_en, e_cap);
    chk("busy", busy, e_busy);
    chk("sample_valid", sample_valid, m_valid);
    chk("sample_data", sample_data, m_data);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic step();
    bit v_old;
    int f;
    if (rnd_hs) begin
      sample_done  = ($urandom_range(3) == 0);
      sample_in    = 8'($urandom);
      sample_ready = ($urandom_range(1) == 1);
      clr_ovr      = ($urandom_range(7) == 0);
    end
    if (rst) begin
      act = 0; m_valid = 0; m_data = 8'd128; m_ovr = 0;
    end else begin
      if (!act) begin
        if (en) begin
          act = 1; t0 = cyc + 1; drain_t = -1; stop_t = -1;
          h = (div_cfg < 8'd2) ? 2 : int'(div_cfg);
        end
      end else if (drain_t < 0 && (cyc - t0) >= 2 * h && !en) begin
        drain_t = cyc - t0 + 1;
        f = 2 * BPC * 2 * h;
        stop_t = 2 * h + ((drain_t - 2 * h) / f + 1) * f;
      end
      v_old = m_valid;
      if (sample_done && (!v_old || sample_ready)) begin
        m_valid = 1; m_data = sample_in;
      end else if (v_old && sample_ready) m_valid = 0;
      if (sample_done && v_old && !sample_ready) m_ovr = 1;
      else if (clr_ovr) m_ovr = 0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (act && stop_t >= 0 && (cyc - t0) >= stop_t) act = 0;
    frame_exp();
    check_all();
    prev_sclk = e_sclk;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic hs(input bit d, input logic [7:0] din, input bit rdy, input bit clr);
    sample_done = d; sample_in = din; sample_ready = rdy; clr_ovr = clr;
    step();
  endtask

  task automatic wait_bit(input int b, input string tag);
    int n = 0;
    while (!(act && drain_t < 0 && (cyc - t0) >= 2 * h && e_bit == b && !e_ws) && n < 4000) begin
      step(); n++;
    end
    chk(tag, n < 4000, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (act && n < 4000) begin
      step(); n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic restart(input logic [7:0] cfg, input int drop_bit);
    wait_bit(drop_bit, "reach_drop_bit");
    en = 0;
    wait_idle("drain_idle");
    chk("drain_ws", ws, 0);
    chk("drain_sclk", sclk, 0);
    div_cfg = cfg;
    en = 1;
  endtask

  initial begin
    run(2);
    chk("rst_data", sample_data, 8'd128);
    chk("rst_busy", busy, 0);
    rst = 0;
    div_cfg = 8'd2;
    en = 1;
    hs(1, 8'hA5, 1, 0);
    chk("hs_a5_data", sample_data, 8'hA5);
    chk("hs_a5_valid", sample_valid, 1);
    hs(0, 8'h00, 1, 0);
    chk("hs_a5_consumed", sample_valid, 0);
    hs(1, 8'hA5, 0, 0);
    hs(1, 8'h3C, 0, 0);
    chk("ovr_keep_data", sample_data, 8'hA5);
    chk("ovr_set", overrun, 1);
    hs(0, 8'h00, 0, 0);
    hs(0, 8'h00, 0, 0);
    chk("ovr_sticky", overrun, 1);
    hs(0, 8'h00, 1, 1);
    chk("ovr_cleared", overrun, 0);
    hs(1, 8'h11, 0, 0);
    hs(1, 8'h77, 1, 0);
    chk("simul_data", sample_data, 8'h77);
    chk("simul_valid", sample_valid, 1);
    chk("simul_ovr", overrun, 0);
    hs(1, 8'h22, 0, 0);
    hs(1, 8'h33, 0, 1);
    chk("ovr_set_wins", overrun, 1);
    rnd_hs = 1;
    run(600);
    div_cfg = 8'd5;
    run(300);
    // drop en mid left channel, re-raise during drain: restarts with H=5
    wait_bit(10, "reach_bit10");
    en = 0;
    run(20);
    en = 1;
    wait_idle("drain_reassert_idle");
    run(1400);
    wait_bit(17, "reach_bit17");
    #20 rst = 1;
    #1;
    chk("arst_sclk", sclk, 0);
    chk("arst_ws", ws, 0);
    chk("arst_bit", bit_idx, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", sample_data, 8'd128);
    chk("arst_valid", sample_valid, 0);
    act = 0; m_valid = 0; m_data = 8'd128; m_ovr = 0; prev_sclk = 0;
    step();
    rst = 0;
    run(300);
    restart(8'd0, 10);
    run(600);
    restart(8'd1, 3);
    run(600);
    for (int it = 0; it < 3; it++) begin
      restart(8'($urandom_range(6)), $urandom_range(31));
      run($urandom_range(900, 300));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
